// File: rtl/timed_chip_pkg.sv
// Shared types and width helpers for the cycle-timed DRAM device model.
`timescale 1ns/1ps
package timed_chip_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ACT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        PRE  = 3'd4,
        PREA = 3'd5,
        REF  = 3'd6
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVATING,
        ACTIVE,
        PRECHARGING
    } bank_state_e;

    localparam int CMD_W = 3;

    // Bits needed to hold a down-counter loaded with max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/timed_bank_fsm.sv
// Row-buffer state machine for one DRAM bank: tRCD/tRP timing and the latched open row.
`timescale 1ns/1ps
module timed_bank_fsm
    import timed_chip_pkg::*;
#(
    parameter int ROWWIDTH = 5,
    parameter int TRCD     = 2,
    parameter int TRP      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                act,
    input  logic                pre,
    input  logic [ROWWIDTH-1:0] row,
    output logic                is_idle,
    output logic                is_activating,
    output logic                is_active,
    output logic                is_precharging,
    output logic [ROWWIDTH-1:0] open_row
);

    localparam int CW = cnt_width((TRCD > TRP) ? TRCD : TRP);

    bank_state_e   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (act && state == IDLE)
            open_row <= row;
    end

    // Counter holds the cycles still to wait after the current one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (act) begin
                    state_nxt = (TRCD == 1) ? ACTIVE : ACTIVATING;
                    cnt_nxt   = CW'(TRCD - 1);
                end
            end
            ACTIVATING: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (pre) begin
                    state_nxt = (TRP == 1) ? IDLE : PRECHARGING;
                    cnt_nxt   = CW'(TRP - 1);
                end
            end
            PRECHARGING: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign is_idle        = (state == IDLE);
    assign is_activating  = (state == ACTIVATING);
    assign is_active      = (state == ACTIVE);
    assign is_precharging = (state == PRECHARGING);

endmodule

// File: rtl/timed_chip.sv
// Cycle-timed DRAM device: command decode, per-bank FSMs, burst engine and storage.
// Optional refresh support is enabled by defining TIMED_CHIP_REFRESH_EN.
`timescale 1ns/1ps
module timed_chip
    import timed_chip_pkg::*;
#(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ROWWIDTH     = 5,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int TRCD         = 2,
    parameter int TRP          = 2,
    parameter int TCL          = 2,
    parameter int TRFC         = 8,
    localparam int NBANKS      = (2**BGWIDTH) * (2**BAWIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CMD_W-1:0]        cmd,
    input  logic [BGWIDTH-1:0]      cmd_bg,
    input  logic [BAWIDTH-1:0]      cmd_ba,
    input  logic [ROWWIDTH-1:0]     cmd_row,
    input  logic [COLWIDTH-1:0]     cmd_col,
    input  logic [DEVICE_WIDTH-1:0] wr_data,
    output logic [DEVICE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    err,
    output logic [NBANKS-1:0]       bank_open
);

    localparam int BANKW = BGWIDTH + BAWIDTH;
    localparam int ADDRW = BANKW + ROWWIDTH + COLWIDTH;
    localparam int BEATW = cnt_width(BL - 1);
    localparam int DLYW  = cnt_width(TCL - 1);

    cmd_e                cmd_code;
    logic [BANKW-1:0]    bank;
    logic                accept, illegal, cmd_ok, start;
    logic                ref_busy;
    logic [NBANKS-1:0]   act_vec, pre_vec;
    logic [NBANKS-1:0]   idle_vec, activating_vec, active_vec, precharging_vec;
    logic [ROWWIDTH-1:0] open_rows [NBANKS];

    assign cmd_code  = cmd_e'(cmd);
    assign bank      = {cmd_bg, cmd_ba};
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ok    = accept && !illegal;
    assign start     = cmd_ok && (cmd_code == RD || cmd_code == WR);
    assign bank_open = active_vec;

    always_comb begin
        illegal = 1'b0;
        case (cmd_code)
            NOP:     illegal = 1'b0;
            ACT:     illegal = !idle_vec[bank];
            RD, WR:  illegal = !active_vec[bank];
            PRE:     illegal = activating_vec[bank] || precharging_vec[bank];
            PREA:    illegal = |activating_vec;
`ifdef TIMED_CHIP_REFRESH_EN
            REF:     illegal = !(&idle_vec);
`endif
            default: illegal = 1'b1;
        endcase
    end

    // PRE to an IDLE bank reaches the FSM but is ignored there.
    always_comb begin
        act_vec = '0;
        pre_vec = '0;
        if (cmd_ok) begin
            if (cmd_code == ACT)
                act_vec[bank] = 1'b1;
            if (cmd_code == PRE)
                pre_vec[bank] = 1'b1;
            if (cmd_code == PREA)
                pre_vec = active_vec;
        end
    end

    for (genvar i = 0; i < NBANKS; i++) begin : g_bank
        timed_bank_fsm #(
            .ROWWIDTH (ROWWIDTH),
            .TRCD     (TRCD),
            .TRP      (TRP)
        ) u_bank (
            .clk            (clk),
            .rst_n          (rst_n),
            .act            (act_vec[i]),
            .pre            (pre_vec[i]),
            .row            (cmd_row),
            .is_idle        (idle_vec[i]),
            .is_activating  (activating_vec[i]),
            .is_active      (active_vec[i]),
            .is_precharging (precharging_vec[i]),
            .open_row       (open_rows[i])
        );
    end

    // Burst engine: optional TCL wait (reads only), then BL beats.
    logic                busy, is_rd, beat_now;
    logic [DLYW-1:0]     dly;
    logic [BEATW-1:0]    beat;
    logic [BANKW-1:0]    b_bank;
    logic [ROWWIDTH-1:0] b_row;
    logic [COLWIDTH-1:0] b_col;
    logic [ADDRW-1:0]    addr;

    assign beat_now = busy && (dly == '0);
    assign addr     = {b_bank, b_row, b_col};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            is_rd <= 1'b0;
            dly   <= '0;
            beat  <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            is_rd <= (cmd_code == RD);
            dly   <= (cmd_code == RD) ? DLYW'(TCL - 1) : '0;
            beat  <= '0;
        end else if (busy) begin
            if (dly != '0) begin
                dly <= dly - DLYW'(1);
            end else begin
                beat <= beat + BEATW'(1);
                if (beat == BEATW'(BL - 1))
                    busy <= 1'b0;
            end
        end
    end

    // Column wraps within the open row through natural COLWIDTH overflow.
    always_ff @(posedge clk) begin
        if (start) begin
            b_bank <= bank;
            b_row  <= open_rows[bank];
            b_col  <= cmd_col;
        end else if (beat_now) begin
            b_col  <= b_col + COLWIDTH'(1);
        end
    end

    logic [DEVICE_WIDTH-1:0] mem [0:(1 << ADDRW) - 1];

    always_ff @(posedge clk) begin
        if (beat_now && !is_rd)
            mem[addr] <= wr_data;
    end

    assign rd_valid = beat_now && is_rd;
    assign rd_data  = rd_valid ? mem[addr] : '0;

`ifdef TIMED_CHIP_REFRESH_EN
    localparam int RW = cnt_width(TRFC);
    logic [RW-1:0] ref_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ref_cnt <= '0;
        else if (cmd_ok && cmd_code == REF)
            ref_cnt <= RW'(TRFC);
        else if (ref_cnt != '0)
            ref_cnt <= ref_cnt - RW'(1);
    end

    assign ref_busy = (ref_cnt != '0);
`else
    assign ref_busy = 1'b0;
`endif

    assign cmd_ready = !busy && !ref_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else
            err <= accept && illegal;
    end

endmodule
